mips_boot_loader: RTL

Upstream boot stage for the MIPS core. Receives a program as a byte stream over a valid/ready interface and packs it into 32-bit little-endian words. Writes each word into instruction memory at sequential word addresses. Holds the core stopped (cpu_run=0) until the whole image is written, then releases it.

---
 rtl/mips_boot_pkg.sv | 16 +
 rtl/mips_byte_packer.sv | 39 +++
 rtl/mips_boot_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_boot_pkg.sv
// rtl/mips_boot_pkg.sv - shared types and constants for the MIPS boot loader
package mips_boot_pkg;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    FLUSH,
    RUN,
    ERR
  } boot_state_e;

endpackage

// File: rtl/mips_byte_packer.sv
// rtl/mips_byte_packer.sv - assembles four stream bytes into a little-endian 32-bit word
module mips_byte_packer
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_stb,
  input  logic [7:0]  rx_byte,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  cnt;
  logic [23:0] lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lo  <= '0;
    end else if (clear) begin
      cnt <= '0;
      lo  <= '0;
    end else if (byte_stb) begin
      case (cnt)
        2'd0:    lo[7:0]   <= rx_byte;
        2'd1:    lo[15:8]  <= rx_byte;
        2'd2:    lo[23:16] <= rx_byte;
        default: lo        <= '0;
      endcase
      cnt <= cnt + 2'd1;
    end
  end

  // The top byte is taken straight from the stream so the word is complete on the 4th handshake.
  assign word      = {rx_byte, lo};
  assign word_done = byte_stb && (cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_boot_loader.sv
// rtl/mips_boot_loader.sv - streams a length-prefixed image into instruction memory, then releases the core
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              boot_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE_W    = (ADDR_W + 1)'(1);

  boot_state_e       state, state_nx;
  logic              hdr_cnt;
  logic [7:0]        n_lo;
  logic [ADDR_W:0]   n_words;
  logic [15:0]       n_hdr;
  logic              hs;
  logic              hdr_last;
  logic              last_word;
  logic [31:0]       pk_word;
  logic              pk_done;

  assign hs        = rx_valid && rx_ready;
  assign n_hdr     = {rx_data, n_lo};
  assign hdr_last  = hs && (hdr_cnt == 1'(LEN_BYTES - 1));
  assign last_word = pk_done && ((words_loaded + ONE_W) == n_words);

  mips_byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .byte_stb  (hs && (state == LOAD)),
    .rx_byte   (rx_data),
    .clear     (state != LOAD),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ready = 1'b0;
    case (state)
      IDLE:  state_nx = LEN;
      LEN: begin
        rx_ready = 1'b1;
        if (hdr_last) begin
          if (n_hdr == 16'd0)                 state_nx = FLUSH;
          else if ({1'b0, n_hdr} > CAPACITY)  state_nx = ERR;
          else                                state_nx = LOAD;
        end
      end
      LOAD: begin
        rx_ready = 1'b1;
        if (last_word) state_nx = FLUSH;
      end
      FLUSH: state_nx = RUN;
      RUN:   if (boot_req) state_nx = LEN;
      ERR:   state_nx = ERR;
      default: state_nx = IDLE;
    endcase
  end

  assign cpu_run  = (state == RUN);
  assign load_err = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_cnt      <= 1'b0;
      n_lo         <= '0;
      n_words      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state == LEN) begin
        if (hs) begin
          hdr_cnt <= ~hdr_cnt;
          if (!hdr_last) n_lo    <= rx_data;
          else           n_words <= n_hdr[ADDR_W:0];
        end
      end else begin
        hdr_cnt <= 1'b0;
      end
      if ((state_nx == LEN) && (state != LEN)) words_loaded <= '0;
      // Word index is the running count, so addresses restart at 0 for every load.
      if (pk_done) begin
        imem_we      <= 1'b1;
        imem_addr    <= words_loaded[ADDR_W-1:0];
        imem_wdata   <= pk_word;
        words_loaded <= words_loaded + ONE_W;
      end
    end
  end

endmodule
